// File: rtl/phase_map_serializer.sv
// rtl/phase_map_serializer.sv - serializes a captured phase map into a PIN-diode driver shift chain
//
// Captures the flat MAP_SIZE x MAP_SIZE phase map on each rising edge of
// map_valid and shifts it MSB first into the reflectarray driver chain, then
// pulses the storage latch. One further map can be held pending while a frame
// is in flight; a second arrival before it starts overwrites it and flags overrun.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   map_valid      calculator done level; rising edge marks a new map
//   map_in         flat map, bit idx = row*MAP_SIZE+col
//   clr_overrun    synchronous clear of the sticky overrun flag
//   busy           high while a frame is shifting or latching
//   frame_done     1-cycle pulse after each latch pulse
//   overrun        sticky, set when a pending map is overwritten
//   frame_count    completed frames (wraps)
//   sr_clk, sr_data, sr_latch, sr_oe_n   driver chain interface
module phase_map_serializer #(
  parameter int MAP_SIZE     = 16,
  parameter int CLK_DIV      = 2,
  parameter int LATCH_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           map_valid,
  input  logic [MAP_SIZE*MAP_SIZE-1:0]   map_in,
  input  logic                           clr_overrun,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overrun,
  output logic [15:0]                    frame_count,
  output logic                           sr_clk,
  output logic                           sr_data,
  output logic                           sr_latch,
  output logic                           sr_oe_n
);

  localparam int N  = MAP_SIZE * MAP_SIZE;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(N - 1);
  localparam logic [7:0]    DIV_LOAD  = 8'(CLK_DIV - 1);
  localparam logic [7:0]    LAT_LOAD  = 8'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, GAP, LATCH, FIN} state_t;

  state_t          state;
  logic [N-1:0]    shreg;
  logic [N-1:0]    pend;
  logic            pending;
  logic            prev_valid;
  logic            armed;
  logic [BW-1:0]   bitcnt;
  logic [7:0]      cnt;
  logic            rise;

  // armed only goes high once map_valid has been seen low after reset, so a
  // level held high across reset release is not mistaken for a new map.
  assign rise = map_valid & ~prev_valid & armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      pend        <= '0;
      pending     <= 1'b0;
      prev_valid  <= 1'b0;
      armed       <= 1'b0;
      bitcnt      <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
      sr_clk      <= 1'b0;
      sr_data     <= 1'b0;
      sr_latch    <= 1'b0;
      sr_oe_n     <= 1'b1;
    end else begin
      prev_valid <= map_valid;
      if (!map_valid) armed <= 1'b1;
      frame_done <= 1'b0;

      if (clr_overrun) overrun <= 1'b0;

      // Any rise outside IDLE (FIN included) is parked; set beats clear.
      if (rise && state != IDLE) begin
        pend    <= map_in;
        pending <= 1'b1;
        if (pending) overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rise || pending) begin
            // The older pending map goes first; a coincident rise replaces it
            // in the buffer without counting as an overrun.
            if (pending) begin
              shreg   <= pend;
              sr_data <= pend[N-1];
              if (rise) pend <= map_in;
              else      pending <= 1'b0;
            end else begin
              shreg   <= map_in;
              sr_data <= map_in[N-1];
            end
            bitcnt <= LAST_BIT;
            cnt    <= DIV_LOAD;
            busy   <= 1'b1;
            sr_clk <= 1'b0;
            state  <= LOW;
          end
        end
        LOW: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else begin
            sr_clk <= 1'b1;
            cnt    <= DIV_LOAD;
            state  <= HIGH;
          end
        end
        HIGH: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else begin
            sr_clk <= 1'b0;
            cnt    <= DIV_LOAD;
            if (bitcnt == '0) begin
              sr_data <= 1'b0;
              state   <= GAP;
            end else begin
              // Next bit is presented on the falling edge, a full half-period
              // ahead of the following rising edge.
              bitcnt  <= bitcnt - 1'b1;
              sr_data <= shreg[bitcnt - 1'b1];
              state   <= LOW;
            end
          end
        end
        GAP: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else begin
            sr_latch <= 1'b1;
            cnt      <= LAT_LOAD;
            state    <= LATCH;
          end
        end
        LATCH: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else begin
            sr_latch    <= 1'b0;
            frame_done  <= 1'b1;
            busy        <= 1'b0;
            frame_count <= frame_count + 16'd1;
            sr_oe_n     <= 1'b0;
            state       <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_map_serializer.sv
// tb/tb_phase_map_serializer.sv - directed self-checking bench for phase_map_serializer
module tb_phase_map_serializer;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          map_valid = 1'b0;
  logic [N-1:0]  map_in = '0;
  logic          clr_overrun = 1'b0;
  logic          busy, frame_done, overrun;
  logic [15:0]   frame_count;
  logic          sr_clk, sr_data, sr_latch, sr_oe_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  phase_map_serializer #(
    .MAP_SIZE(4),
    .CLK_DIV(1),
    .LATCH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .map_valid(map_valid),
    .map_in(map_in),
    .clr_overrun(clr_overrun),
    .busy(busy),
    .frame_done(frame_done),
    .overrun(overrun),
    .frame_count(frame_count),
    .sr_clk(sr_clk),
    .sr_data(sr_data),
    .sr_latch(sr_latch),
    .sr_oe_n(sr_oe_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: collects bits on sr_clk rising edges, latch width and done time.
  logic        last_clk = 1'b0;
  logic [15:0] word = '0;
  int          nbits = 0;
  int          latch_len = 0;
  int          ndone = 0;
  logic [15:0] dword [0:15];
  int          dbits [0:15];
  int          dlatch[0:15];
  int          dcyc  [0:15];

  always @(negedge clk) begin
    if (rst) begin
      last_clk  = 1'b0;
      word      = '0;
      nbits     = 0;
      latch_len = 0;
    end else begin
      if (sr_clk && !last_clk) begin
        word  = {word[14:0], sr_data};
        nbits = nbits + 1;
      end
      last_clk = sr_clk;
      if (sr_latch) latch_len = latch_len + 1;
      if (frame_done) begin
        if (ndone < 16) begin
          dword[ndone]  = word;
          dbits[ndone]  = nbits;
          dlatch[ndone] = latch_len;
          dcyc[ndone]   = cyc;
        end
        ndone     = ndone + 1;
        word      = '0;
        nbits     = 0;
        latch_len = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (ndone < target && n < 400) begin
      tick();
      n++;
    end
    check("frame_wait", 32'(ndone >= target), 32'd1);
  endtask

  task automatic pulse(input logic [N-1:0] v);
    map_in    = v;
    map_valid = 1'b1;
    tick();
    map_valid = 1'b0;
    tick();
  endtask

  int rise_cyc;
  int n;

  initial begin
    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    repeat (10) tick();
    check("reset_outs", {25'd0, busy, frame_done, overrun, sr_clk, sr_data, sr_latch, sr_oe_n}, 32'b0000001);
    check("reset_count", 32'(frame_count), 32'd0);

    // Frame 0: A5C3 with map_valid held high
    map_in    = 16'hA5C3;
    map_valid = 1'b1;
    tick();
    rise_cyc = cyc;
    check("busy_after_rise", 32'(busy), 32'd1);
    wait_frames(1);
    check("f0_word", 32'(dword[0]), 32'hA5C3);
    check("f0_bits", 32'(dbits[0]), 32'd16);
    check("f0_latch", 32'(dlatch[0]), 32'd2);
    // LOW visible one edge after the rise; 32 shift + 1 gap + 2 latch cycles
    check("f0_latency", 32'(dcyc[0] - rise_cyc), 32'd35);
    check("f0_count", 32'(frame_count), 32'd1);
    check("f0_oe_n", 32'(sr_oe_n), 32'd0);
    repeat (40) tick();
    check("held_no_refire", 32'(ndone), 32'd1);
    check("held_idle", 32'(busy), 32'd0);
    map_valid = 1'b0;
    tick();

    // Frames 1,2: F00F then pending 00FF
    pulse(16'hF00F);
    repeat (3) tick();
    pulse(16'h00FF);
    map_in = 16'hDEAD;
    wait_frames(3);
    check("f1_word", 32'(dword[1]), 32'hF00F);
    check("f2_word", 32'(dword[2]), 32'h00FF);
    // FIN, one IDLE cycle, then a full 35-cycle frame
    check("pending_gap", 32'(dcyc[2] - dcyc[1]), 32'd37);
    check("f2_overrun", 32'(overrun), 32'd0);
    check("f2_count", 32'(frame_count), 32'd3);

    // Frames 3,4: two arrivals during one frame, latest wins
    pulse(16'hAAAA);
    pulse(16'h1111);
    check("one_pending_no_overrun", 32'(overrun), 32'd0);
    pulse(16'h2222);
    check("overrun_set", 32'(overrun), 32'd1);
    wait_frames(5);
    check("f3_word", 32'(dword[3]), 32'hAAAA);
    check("f4_word", 32'(dword[4]), 32'h2222);
    check("overrun_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);
    check("f4_count", 32'(frame_count), 32'd5);

    // Reset mid-frame
    pulse(16'h1234);
    n = 0;
    while (nbits < 7 && n < 100) begin
      tick();
      n++;
    end
    check("reach_bit7", 32'(nbits), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_outs", {26'd0, sr_clk, sr_latch, busy, sr_oe_n, frame_done, overrun}, 32'b000100);
    check("rst_mid_count", 32'(frame_count), 32'd0);
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    pulse(16'hBEEF);
    wait_frames(6);
    check("after_rst_word", 32'(dword[5]), 32'hBEEF);
    check("after_rst_bits", 32'(dbits[5]), 32'd16);
    check("after_rst_count", 32'(frame_count), 32'd1);

    // map_valid held high across reset release
    rst       = 1'b1;
    map_in    = 16'h5555;
    map_valid = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (60) tick();
    check("held_rst_no_frame", 32'(ndone), 32'd6);
    check("held_rst_busy", 32'(busy), 32'd0);
    map_valid = 1'b0;
    tick();
    pulse(16'h0F0F);
    wait_frames(7);
    check("rearm_word", 32'(dword[6]), 32'h0F0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
